// File: rtl/seq_commit_unit.sv
// In-order commit tracker: hands out sequence numbers, absorbs out-of-order
// completions, and retires entries strictly in sequence order with squash support.
module seq_commit_unit #(
  parameter int p_seq_num_bits = 5,
  parameter int p_depth        = 8
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      alloc_val,
  output logic                      alloc_rdy,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,

  input  logic                      complete_val,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  input  logic [31:0]               complete_pc,
  input  logic [4:0]                complete_waddr,
  input  logic [31:0]               complete_wdata,
  input  logic                      complete_wen,

  input  logic                      squash_val,
  input  logic [p_seq_num_bits-1:0] squash_seq_num,

  output logic                      commit_val,
  output logic [31:0]               commit_pc,
  output logic [p_seq_num_bits-1:0] commit_seq_num,
  output logic [4:0]                commit_waddr,
  output logic [31:0]               commit_wdata,
  output logic                      commit_wen
);

  localparam int idx_bits = $clog2(p_depth);
  localparam int cnt_bits = $clog2(p_depth + 1);

  logic [p_depth-1:0]        valid_q;
  logic [p_depth-1:0]        complete_q;
  logic [p_seq_num_bits-1:0] head_q;
  logic [p_seq_num_bits-1:0] tail_q;
  logic [cnt_bits-1:0]       count_q;

  logic [31:0]        pc_mem    [p_depth];
  logic [4:0]         waddr_mem [p_depth];
  logic [31:0]        wdata_mem [p_depth];
  logic [p_depth-1:0] wen_mem;

  logic [idx_bits-1:0]       head_idx;
  logic [idx_bits-1:0]       tail_idx;
  logic [idx_bits-1:0]       cpl_idx;
  logic [p_seq_num_bits-1:0] count_ext;
  logic [p_seq_num_bits-1:0] cpl_off;
  logic [p_seq_num_bits-1:0] sq_off;
  logic                      squash_fire;
  logic                      alloc_fire;
  logic                      cpl_fire;
  logic [p_depth-1:0]        squash_mask;
  logic [p_depth-1:0]        commit_clr;
  logic [p_depth-1:0]        alloc_set;
  logic [p_depth-1:0]        cpl_set;
  logic [p_depth-1:0]        valid_nxt;
  logic [p_depth-1:0]        complete_nxt;
  logic [cnt_bits-1:0]       count_nxt;
  logic [p_seq_num_bits-1:0] tail_nxt;

  // p_depth divides 2**p_seq_num_bits, so the low bits of a sequence number are its slot.
  assign head_idx  = head_q[idx_bits-1:0];
  assign tail_idx  = tail_q[idx_bits-1:0];
  assign cpl_idx   = complete_seq_num[idx_bits-1:0];
  assign count_ext = p_seq_num_bits'(count_q);

  // Age relative to head; anything at or beyond count is not in flight.
  assign cpl_off = complete_seq_num - head_q;
  assign sq_off  = squash_seq_num - head_q;

  assign squash_fire = squash_val && (sq_off < count_ext);
  assign alloc_rdy   = (count_q != cnt_bits'(p_depth)) && !squash_val;
  assign alloc_fire  = alloc_val && alloc_rdy;
  assign cpl_fire    = complete_val && (cpl_off < count_ext) && !complete_q[cpl_idx] &&
                       !(squash_fire && (cpl_off > sq_off));

  assign alloc_seq_num  = tail_q;
  assign commit_val     = valid_q[head_idx] && complete_q[head_idx];
  assign commit_seq_num = head_q;
  assign commit_pc      = pc_mem[head_idx];
  assign commit_waddr   = waddr_mem[head_idx];
  assign commit_wdata   = wdata_mem[head_idx];
  assign commit_wen     = wen_mem[head_idx];

  always_comb begin
    squash_mask = '0;
    for (int i = 0; i < p_depth; i++) begin
      squash_mask[i] = squash_fire && ((idx_bits'(i) - head_idx) > sq_off[idx_bits-1:0]);
    end
  end

  assign commit_clr = p_depth'(commit_val) << head_idx;
  assign alloc_set  = p_depth'(alloc_fire) << tail_idx;
  assign cpl_set    = p_depth'(cpl_fire) << cpl_idx;

  assign valid_nxt    = (valid_q & ~squash_mask & ~commit_clr) | alloc_set;
  assign complete_nxt = ((complete_q & ~squash_mask & ~commit_clr) | cpl_set) & ~alloc_set;

  always_comb begin
    count_nxt = count_q + cnt_bits'(alloc_fire) - cnt_bits'(commit_val);
    tail_nxt  = tail_q + p_seq_num_bits'(alloc_fire);
    if (squash_fire) begin
      // A same-cycle head commit still retires; alloc is already blocked.
      count_nxt = cnt_bits'(sq_off) + cnt_bits'(1) - cnt_bits'(commit_val);
      tail_nxt  = squash_seq_num + p_seq_num_bits'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_nxt;
      complete_q <= complete_nxt;
      head_q     <= head_q + p_seq_num_bits'(commit_val);
      tail_q     <= tail_nxt;
      count_q    <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (cpl_fire) begin
      pc_mem[cpl_idx]    <= complete_pc;
      waddr_mem[cpl_idx] <= complete_waddr;
      wdata_mem[cpl_idx] <= complete_wdata;
      wen_mem[cpl_idx]   <= complete_wen;
    end
  end

endmodule
